sseg_scan_driver: RTL and testbench

SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

---
 rtl/sseg_scan_driver.sv | 73 +++++++
 tb/tb_sseg_scan_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: scans a 32-bit word across eight active-low 7-segment digits; ports clk, rst, value/load (word capture), full/empty (dp flags), an/seg/dp (display drive); define SSEG_LZ_BLANK_EN for leading-zero blanking
module sseg_scan_driver #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        load,
  input  logic        full,
  input  logic        empty,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic [2:0]    digit;
  logic [31:0]   value_reg;
  logic          tick, lit, dp_on;
  logic [3:0]    nib;
  logic [6:0]    dec;
  assign tick  = cnt == CW'(CLK_DIV - 1);
  assign nib   = value_reg[{digit, 2'b00} +: 4];
  assign dp_on = ~tick & ((digit == 3'd0 & full) | (digit == 3'd1 & empty));
`ifdef SSEG_LZ_BLANK_EN
  logic [2:0] msd;
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 8; i++)
      if (value_reg[4*i +: 4] != 4'h0) msd = 3'(i);
  end
  assign lit = ~tick & (digit <= msd);
`else
  assign lit = ~tick;
`endif
  always_comb begin
    case (nib)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      default: dec = 7'h0E;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      digit     <= 3'd0;
      value_reg <= 32'h0;
      an        <= 8'hFF;
      seg       <= 7'h7F;
      dp        <= 1'b1;
    end else begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      digit <= digit + 3'(tick);
      if (load) value_reg <= value;
      an    <= lit ? ~(8'b1 << digit) : 8'hFF;
      seg   <= lit ? dec : 7'h7F;
      dp    <= ~dp_on;
    end
  end
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: scoreboard bench for sseg_scan_driver at CLK_DIV=4
module tb_sseg_scan_driver;
  localparam int CLK_DIV = 4;
  logic clk = 0, rst = 1, load = 0, full = 0, empty = 0;
  logic [31:0] value = 0;
  logic [7:0] an;
  logic [6:0] seg;
  logic dp;
  int n_assert = 0, n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  int m_cnt = 0, m_dig = 0;
  logic [31:0] m_val = 0;
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sseg_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .full(full), .empty(empty),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_out();
    logic lit, dpv;
    int nib, msd;
    if (rst || m_cnt == CLK_DIV - 1) return {8'hFF, 7'h7F, 1'b1};
    nib = int'((m_val >> (4 * m_dig)) & 32'hF);
    msd = 0;
    for (int i = 0; i < 8; i++) if (((m_val >> (4 * i)) & 32'hF) != 0) msd = i;
`ifdef SSEG_LZ_BLANK_EN
    lit = m_dig <= msd;
`else
    lit = 1'b1;
`endif
    dpv = !((m_dig == 0 && full) || (m_dig == 1 && empty));
    return lit ? {~(8'b1 << m_dig), hex_tab[nib], dpv} : {8'hFF, 7'h7F, dpv};
  endfunction

  task automatic step();
    exp_q.push_back(model_out());
    if (rst) begin
      m_cnt = 0; m_dig = 0; m_val = 0;
    end else begin
      if (load) m_val = value;
      if (m_cnt == CLK_DIV - 1) begin
        m_cnt = 0; m_dig = (m_dig + 1) % 8;
      end else m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_assert++;
      if ({an, seg, dp} !== mon_e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                 $time, an, seg, dp, mon_e[15:8], mon_e[7:1], mon_e[0]);
      end
    end
  end

  task automatic test_reset();
    rst = 1; step(); step();
    rst = 0;
    n_assert++;
    if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_fail++; $display("FAIL reset_state got %h/%h/%b expected FF/7F/1", an, seg, dp);
    end
    step();
    n_assert++;
    if (an !== 8'hFE) begin
      n_fail++; $display("FAIL reset_first_slot got an=%h expected FE", an);
    end
  endtask

  task automatic test_scan();
    logic [7:0] ea [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] es [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    int guard = 0;
    value = 32'h89ABCDEF; load = 1; step(); load = 0;
    while (!(m_cnt == 0 && m_dig == 0) && guard < 64) begin step(); guard++; end
    n_assert++;
    if (guard >= 64) begin
      n_fail++; $display("FAIL scan_sync got timeout expected slot 0 start");
    end
    for (int k = 0; k < 8; k++) begin
      step();
      n_assert++;
      if (an !== ea[k] || seg !== es[k]) begin
        n_fail++; $display("FAIL scan_slot%0d got an=%h seg=%h expected an=%h seg=%h", k, an, seg, ea[k], es[k]);
      end
      step(); step(); step();
      n_assert++;
      if (an !== 8'hFF) begin
        n_fail++; $display("FAIL scan_blank%0d got an=%h expected FF", k, an);
      end
    end
  endtask

  task automatic test_lz();
    int hi_lit = 0, hi_bad = 0, s1_bad = 0;
    value = 32'h00000020; load = 1; step(); load = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (an === 8'hFD && seg !== 7'h24) s1_bad++;
      if (an !== 8'hFF && an !== 8'hFE && an !== 8'hFD) begin
        hi_lit++;
        if (seg !== 7'h40) hi_bad++;
      end
    end
    n_assert++;
    if (s1_bad != 0) begin
      n_fail++; $display("FAIL lz_slot1 got %0d bad cycles expected 0", s1_bad);
    end
`ifdef SSEG_LZ_BLANK_EN
    n_assert++;
    if (hi_lit != 0) begin
      n_fail++; $display("FAIL lz_blank got %0d lit upper cycles expected 0", hi_lit);
    end
`else
    n_assert++;
    if (hi_lit == 0 || hi_bad != 0) begin
      n_fail++; $display("FAIL lz_off got lit=%0d bad=%0d expected lit>0 bad=0", hi_lit, hi_bad);
    end
`endif
  endtask

  task automatic test_dp();
    int bad = 0, s0 = 0, s1 = 0;
    full = 1; empty = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (dp === 1'b0) begin
        if (an === 8'hFE) s0++;
        else if (an === 8'hFD) s1++;
        else bad++;
      end
    end
    n_assert++;
    if (bad != 0 || s0 == 0 || s1 == 0) begin
      n_fail++; $display("FAIL dp_set got bad=%0d s0=%0d s1=%0d expected 0/>0/>0", bad, s0, s1);
    end
    full = 0; empty = 0; step(); bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (dp !== 1'b1) bad++;
    end
    n_assert++;
    if (bad != 0) begin
      n_fail++; $display("FAIL dp_clear got %0d dp-low cycles expected 0", bad);
    end
  endtask

  task automatic test_load_tick();
    int guard = 0;
    value = 32'h0; load = 1; step(); load = 0;
    for (int k = 0; k < 8; k++) step();
    while (m_cnt != CLK_DIV - 1 && guard < 16) begin step(); guard++; end
    value = 32'h11111111; load = 1; step(); load = 0;
    n_assert++;
    if (an !== 8'hFF) begin
      n_fail++; $display("FAIL load_tick_blank got an=%h expected FF", an);
    end
    step();
    n_assert++;
    if (an === 8'hFF || seg !== 7'h79) begin
      n_fail++; $display("FAIL load_tick_slot got an=%h seg=%h expected lit seg=79", an, seg);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (an !== 8'hDF && guard < 64) begin step(); guard++; end
    n_assert++;
    if (an !== 8'hDF) begin
      n_fail++; $display("FAIL mid_sync got an=%h expected DF", an);
    end
    rst = 1; step(); rst = 0;
    n_assert++;
    if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_fail++; $display("FAIL mid_blank got %h/%h/%b expected FF/7F/1", an, seg, dp);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_assert++;
      if (an !== 8'hFE || seg !== 7'h40) begin
        n_fail++; $display("FAIL mid_slot0_%0d got an=%h seg=%h expected FE/40", k, an, seg);
      end
    end
    step();
    n_assert++;
    if (an !== 8'hFF) begin
      n_fail++; $display("FAIL mid_end got an=%h expected FF", an);
    end
    step();
    n_assert++;
    if (an === 8'hFD || an === 8'hFF) ;
    else begin
      n_fail++; $display("FAIL mid_next got an=%h expected FD or FF", an);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_dp();
    test_load_tick();
    test_reset_mid();
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
